uart_tx_block: RTL and testbench
================================

Name: uart_tx_block

Overview:
- Serial transmitter. It is the sending end of the asynchronous serial link whose receive side our flex_counter-based timing blocks already serve.
- Accepts a parallel byte with a single-cycle start request and shifts out a frame on one line, LSB first: start bit (0), data bits, optional even parity bit, stop bit (1).
- Bit timing is derived internally from a clock-per-bit counter. No baud-rate input is required.

Parameters:
- NUM_DATA_BITS, 8, number of data bits per frame (legal range 5..8).
- CLKS_PER_BIT, 10, clock cycles per serial bit period (minimum 2).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- tx_start  input  1  request to send. Sampled only while the block is idle.
- tx_data  input  NUM_DATA_BITS  byte to send. Captured on the accepting edge.
- parity_en  input  1  1 = append an even-parity bit. Captured on the accepting edge.
- serial_out  output  1  serial line, registered. Idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, n_rst).
  - On reset, serial_out=1, tx_busy=0, tx_done=0, FSM=IDLE, and all counters and shift registers are 0.
  - Reset asserted mid-frame aborts the frame immediately. serial_out returns high with no glitch to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - serial_out=1.
  - If tx_start=1 on a rising edge, the block captures tx_data and parity_en, computes parity as the XOR of the data bits, and moves to START.
  - serial_out drives 0 from that edge onward, so the start bit appears one cycle after tx_start is seen high (latency 1).
- START: holds 0 for exactly CLKS_PER_BIT cycles, then moves to DATA.
- DATA:
  - Sends bit 0 first, then bits 1..NUM_DATA_BITS-1, each for CLKS_PER_BIT cycles.
  - Bit index counts 0..NUM_DATA_BITS-1.
  - After the last bit, moves to PARITY if the captured parity_en=1, else to STOP.
- PARITY: drives the even-parity bit (XOR of the captured data) for CLKS_PER_BIT cycles, then moves to STOP.
- STOP: drives 1 for CLKS_PER_BIT cycles, then moves to IDLE.
- Frame length: (2 + NUM_DATA_BITS + parity) × CLKS_PER_BIT cycles, measured from the first 0 cycle to the end of the stop bit.
- Bit timer:
  - Counts 1..CLKS_PER_BIT and is cleared on every state entry.
  - Its wrap marks the bit boundary. There are no partial or extended bits.
- tx_busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE. Registered, so it rises on the same edge serial_out first goes 0.
- tx_done:
  - High for exactly one cycle, on the first cycle back in IDLE after the stop bit.
  - Never asserts after a reset abort.
- Back-to-back frames: tx_start is honoured in any IDLE cycle, including the tx_done cycle. A request on the tx_done cycle gives one idle-high cycle between frames.
- tx_start while busy is ignored. It is not queued.
- tx_data and parity_en changes while busy have no effect on the frame in progress.
- tx_start held high continuously sends repeated frames, one per IDLE visit.

Test Plan:
- Reset, then idle for 20 cycles -> serial_out=1, tx_busy=0, tx_done=0 throughout.
- tx_data=8'hA5, parity_en=0, single tx_start pulse:
  - serial_out bit sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 10 cycles.
  - tx_busy high for 100 cycles.
  - tx_done pulses once, 1 cycle wide, on the cycle after the stop bit ends.
- tx_data=8'h07, parity_en=1 -> frame 0,1,1,1,0,0,0,0,0,1(parity),1(stop), 110 cycles total.
- Second tx_start with tx_data=8'hFF issued at cycle 40 of a frame sending 8'h3C, tx_data left at FF -> only the 8'h3C frame is sent. No second frame, tx_done pulses once.
- tx_start held high across tx_done, data 8'h55 then 8'hAA -> two complete frames separated by exactly one idle-high cycle.
- n_rst pulsed low during data bit 3 of a frame -> serial_out=1 and tx_busy=0 immediately. No tx_done. The next tx_start sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_block.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_block
//  Purpose  : Asynchronous serial transmitter. Sends a start bit, the data
//             bits LSB first, an optional even-parity bit and a stop bit.
//             The bit period comes from an internal clock-per-bit counter.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_block #(
    parameter int NUM_DATA_BITS = 8,    // 5..8
    parameter int CLKS_PER_BIT  = 10    // >= 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     tx_start,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    input  logic                     parity_en,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(NUM_DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                   state_q,  state_d;
    logic [CNT_W-1:0]         cnt_q,    cnt_d;
    logic [IDX_W-1:0]         idx_q,    idx_d;
    logic [NUM_DATA_BITS-1:0] shift_q,  shift_d;
    logic                     par_q,    par_d;
    logic                     par_en_q, par_en_d;
    logic                     serial_q, serial_d;
    logic                     busy_q,   busy_d;
    logic                     done_q,   done_d;

    logic                     bit_end;

    // The bit timer counts 1..CLKS_PER_BIT; reaching the top is the bit boundary.
    assign bit_end = (cnt_q == BIT_LAST);

    // State register and all datapath registers; the line idles high in reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so the
    // registered line changes on the very edge that enters each bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        done_d   = 1'b0;
        serial_d = 1'b1;
        busy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_start) begin
                    shift_d  = tx_data;
                    par_en_d = parity_en;
                    par_d    = ^tx_data;
                    idx_d    = '0;
                    cnt_d    = CNT_W'(1);
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = CNT_W'(1);
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = CNT_W'(1);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_block.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_block
//  Purpose  : Self-checking bench for uart_tx_block. A frame-level model
//             predicts the line, busy and done outputs every cycle; directed
//             scenarios add hand-computed frame and timing expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_block;

    localparam int NDB = 8;
    localparam int CPB = 10;

    logic           clk;
    logic           n_rst;
    logic           tx_start;
    logic [NDB-1:0] tx_data;
    logic           parity_en;
    logic           serial_out;
    logic           tx_busy;
    logic           tx_done;

    uart_tx_block #(
        .NUM_DATA_BITS (NDB),
        .CLKS_PER_BIT  (CPB)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .parity_en  (parity_en),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a list of line bits, each lasting CPB cycles.
    logic        m_active;
    logic        m_done;
    int          m_t;
    int          m_len;
    logic [10:0] m_frame;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_t      <= 0;
            m_len    <= 0;
            m_frame  <= '0;
        end else if (m_active) begin
            if (m_t + 1 == m_len) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_t      <= 0;
            end else begin
                m_t    <= m_t + 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (tx_start === 1'b1) begin
                m_active <= 1'b1;
                m_t      <= 0;
                if (parity_en) begin
                    m_frame <= {1'b1, ^tx_data, tx_data, 1'b0};
                    m_len   <= 11 * CPB;
                end else begin
                    m_frame <= {1'b0, 1'b1, tx_data, 1'b0};
                    m_len   <= 10 * CPB;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("serial_out", serial_out, m_active ? m_frame[m_t / CPB] : 1'b1);
            chk("tx_busy",    tx_busy,    m_active);
            chk("tx_done",    tx_done,    m_done);
        end
    end

    // Running totals of busy cycles and done pulses; scenarios take differences.
    int busy_total = 0;
    int done_total = 0;
    always @(negedge clk) begin
        if (tx_busy === 1'b1) busy_total <= busy_total + 1;
        if (tx_done === 1'b1) done_total <= done_total + 1;
    end

    // Issue one request, sample the middle of every line bit, then check the
    // done pulse that follows the stop bit.
    task automatic send_capture(input logic [NDB-1:0] data, input logic par,
                                input int nbits, output logic [10:0] bits);
        @(negedge clk);
        tx_data   = data;
        parity_en = par;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        bits      = '0;
        for (int c = 0; c < nbits * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (c % CPB == CPB / 2) bits[c / CPB] = serial_out;
        end
        @(negedge clk);
        chk("done_after_stop", tx_done, 1'b1);
        chk("idle_after_stop", serial_out, 1'b1);
        @(negedge clk);
        chk("done_width", tx_done, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [10:0] bits;
        int          b0;
        int          d0;
        bit          found;

        n_rst     = 1'b0;
        tx_start  = 1'b0;
        tx_data   = '0;
        parity_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_serial", serial_out, 1'b1);
        chk("reset_busy",   tx_busy,    1'b0);
        chk("reset_done",   tx_done,    1'b0);
        n_rst = 1'b1;

        // Idle for 20 cycles.
        @(negedge clk);
        b0 = busy_total; d0 = done_total;
        repeat (20) begin
            @(negedge clk);
            chk("idle_serial", serial_out, 1'b1);
        end
        @(negedge clk);
        chk("idle_busy_cycles", busy_total - b0, 0);
        chk("idle_done_pulses", done_total - d0, 0);

        // A5 without parity.
        b0 = busy_total; d0 = done_total;
        send_capture(8'hA5, 1'b0, 10, bits);
        chk("frame_A5_bits", bits[9:0], 10'b1101001010);
        chk("frame_A5_busy", busy_total - b0, 100);
        chk("frame_A5_done", done_total - d0, 1);

        // 07 with even parity.
        b0 = busy_total; d0 = done_total;
        send_capture(8'h07, 1'b1, 11, bits);
        chk("frame_07p_bits", bits, 11'b11000001110);
        chk("frame_07p_busy", busy_total - b0, 110);
        chk("frame_07p_done", done_total - d0, 1);

        // Request while busy is dropped.
        b0 = busy_total; d0 = done_total;
        @(negedge clk);
        tx_data = 8'h3C; parity_en = 1'b0; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (40) @(negedge clk);
        tx_data = 8'hFF; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (100) @(negedge clk);
        chk("ignore_busy_cycles", busy_total - b0, 100);
        chk("ignore_done_pulses", done_total - d0, 1);

        // Start held across done: back-to-back frames with one idle cycle.
        b0 = busy_total; d0 = done_total;
        @(negedge clk);
        tx_data = 8'h55; parity_en = 1'b0; tx_start = 1'b1;
        @(negedge clk);
        tx_data = 8'hAA;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) found = 1'b1;
        end
        chk("b2b_gap_seen", found, 1'b1);
        chk("b2b_gap_serial", serial_out, 1'b1);
        chk("b2b_gap_done", tx_done, 1'b1);
        @(negedge clk);
        chk("b2b_restart_busy", tx_busy, 1'b1);
        chk("b2b_restart_serial", serial_out, 1'b0);
        repeat (5) @(negedge clk);
        tx_start = 1'b0;
        repeat (110) @(negedge clk);
        chk("b2b_busy_cycles", busy_total - b0, 200);
        chk("b2b_done_pulses", done_total - d0, 2);

        // Reset during data bit 3 aborts cleanly.
        @(negedge clk);
        tx_data = 8'hF7; parity_en = 1'b0; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (43) @(negedge clk);
        chk("bit3_before_reset", serial_out, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_serial", serial_out, 1'b1);
        chk("abort_busy",   tx_busy,    1'b0);
        chk("abort_done",   tx_done,    1'b0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        d0 = done_total;
        repeat (120) @(negedge clk);
        chk("abort_no_done", done_total - d0, 0);

        b0 = busy_total; d0 = done_total;
        send_capture(8'hA5, 1'b1, 11, bits);
        chk("post_abort_bits", bits, 11'b10101001010);
        chk("post_abort_busy", busy_total - b0, 110);
        chk("post_abort_done", done_total - d0, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
